signed_block_accumulator: RTL

Parametrised signed accumulator that sums every block of COUNT signed input samples and presents one registered result per block, with selectable saturating or wrapping arithmetic and a per-block overflow flag. It is the sequential, streaming successor of the team's 8-bit combinational signed adder. It sits between a sample producer and a consumer, with valid/ready handshakes on both sides.

---
 rtl/signed_arith_pkg.sv | 35 +++
 rtl/signed_block_accumulator_if.sv | 24 ++
 rtl/signed_sat_add.sv | 30 +++
 rtl/signed_block_accumulator.sv | 93 +++++++++
 4 files changed

// File: rtl/signed_arith_pkg.sv
// Shared signed-arithmetic helpers: saturation bounds, sign extension and the
// wrap/saturate mode encoding used by the accumulator and later arithmetic blocks.
package signed_arith_pkg;

  typedef enum logic [0:0] {
    ARITH_WRAP = 1'b0,
    ARITH_SAT  = 1'b1
  } arith_mode_e;

  typedef struct packed {
    logic [63:0] max_v;
    logic [63:0] min_v;
  } sat_bounds_t;

  // Two's-complement limits of a signed value of the given width, held in 64 bits.
  function automatic sat_bounds_t sat_bounds(input int width);
    sat_bounds_t b;
    b.max_v = (64'd1 << (width - 1)) - 64'd1;
    b.min_v = ~b.max_v;
    return b;
  endfunction

  // Replicates bit from_w-1 up to bit to_w-1; bits at and above to_w are zero.
  function automatic logic [63:0] sext(input logic [63:0] value, input int from_w, input int to_w);
    logic [63:0] r;
    r = 64'd0;
    for (int i = 0; i < 64; i++) begin
      if (i < from_w) r[i] = value[i];
      else if (i < to_w) r[i] = value[from_w-1];
      else r[i] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/signed_block_accumulator_if.sv
// Sample input and block-result output handshakes of signed_block_accumulator.
interface signed_block_accumulator_if #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic                 clear;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_sum;
  logic                 out_ovf;

  modport master (
    output in_valid, in_data, clear, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_data, clear, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/signed_sat_add.sv
// Combinational signed adder with overflow detect and optional clamping to the
// WIDTH-bit signed range.
module signed_sat_add
  import signed_arith_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int SATURATE = 1
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] sum,
  output logic                    ovf
);
  localparam sat_bounds_t      BOUNDS = sat_bounds(WIDTH);
  localparam logic [WIDTH-1:0] MAX_V  = BOUNDS.max_v[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MIN_V  = BOUNDS.min_v[WIDTH-1:0];

  logic [WIDTH:0] wide_s;

  // One guard bit: the sum is out of range exactly when the top two bits differ.
  always_comb begin
    wide_s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    ovf    = (wide_s[WIDTH] != wide_s[WIDTH-1]);
    if (ovf && (SATURATE == int'(ARITH_SAT))) begin
      sum = wide_s[WIDTH] ? MIN_V : MAX_V;
    end else begin
      sum = wide_s[WIDTH-1:0];
    end
  end
endmodule

// File: rtl/signed_block_accumulator.sv
// Sums each block of COUNT signed samples and holds one registered result per
// block, with a sticky per-block overflow flag.
module signed_block_accumulator
  import signed_arith_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16,
  parameter int COUNT     = 4,
  parameter int SATURATE  = 1
) (
  input logic clk,
  input logic rst,
  signed_block_accumulator_if.slave bus
);
  localparam int              CNT_W    = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

  logic signed [ACC_WIDTH-1:0] acc_r;
  logic signed [ACC_WIDTH-1:0] out_sum_r;
  logic signed [ACC_WIDTH-1:0] sample_ext_s;
  logic signed [ACC_WIDTH-1:0] step_sum_s;
  logic [CNT_W-1:0]            cnt_r;
  logic                        ovf_sticky_r;
  logic                        out_ovf_r;
  logic                        out_valid_r;
  logic                        step_ovf_s;
  logic                        last_s;
  logic                        in_ready_s;
  logic                        accept_s;

  // Handshake decode; a full block stalls only when its result has nowhere to go.
  always_comb begin
    last_s       = (cnt_r == CNT_LAST);
    in_ready_s   = !rst && !bus.clear && !(last_s && out_valid_r && !bus.out_ready);
    accept_s     = bus.in_valid && in_ready_s;
    sample_ext_s = ACC_WIDTH'(sext(64'(bus.in_data), WIDTH, ACC_WIDTH));
  end

  signed_sat_add #(
    .WIDTH    (ACC_WIDTH),
    .SATURATE (SATURATE)
  ) u_step_add (
    .a   (acc_r),
    .b   (sample_ext_s),
    .sum (step_sum_s),
    .ovf (step_ovf_s)
  );

  // Running block state: counter, partial sum and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      acc_r        <= '0;
      cnt_r        <= '0;
      ovf_sticky_r <= 1'b0;
    end else if (accept_s) begin
      if (last_s) begin
        acc_r        <= '0;
        cnt_r        <= '0;
        ovf_sticky_r <= 1'b0;
      end else begin
        acc_r        <= step_sum_s;
        cnt_r        <= cnt_r + CNT_W'(1);
        ovf_sticky_r <= ovf_sticky_r | step_ovf_s;
      end
    end else begin
      acc_r        <= acc_r;
      cnt_r        <= cnt_r;
      ovf_sticky_r <= ovf_sticky_r;
    end
  end

  // Result register; a completing block reloads it even while it is draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_sum_r   <= '0;
      out_ovf_r   <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (accept_s && last_s) begin
      out_sum_r   <= step_sum_s;
      out_ovf_r   <= ovf_sticky_r | step_ovf_s;
      out_valid_r <= 1'b1;
    end else if (out_valid_r && bus.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_sum   = out_sum_r;
  assign bus.out_ovf   = out_ovf_r;
endmodule
